pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/simple_processor_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/pc_fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// ---------------------------------------------------------------------------
// | simple_processor_pkg                                                    |
// | Shared widths, fetch defaults and the fetch controller state type.      |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package simple_processor_pkg;

  localparam int unsigned ADDR_WIDTH        = 16;
  localparam int unsigned DATA_WIDTH        = 16;
  localparam int unsigned FETCH_INSTR_BYTES = 2;
  localparam int unsigned FETCH_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_FETCH   = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// | fetch_fifo                                                              |
// | Synchronous prefetch FIFO with push, pop, flush and occupancy count.    |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// | pc_fetch_ctrl                                                           |
// | PC sequencer issuing single-outstanding fetches into a prefetch FIFO.   |
// | Option: PC_FETCH_ALIGN_CHECK_EN rejects misaligned redirect targets.    |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_ctrl
  import simple_processor_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH = DATA_WIDTH,
  parameter int unsigned INSTR_BYTES    = FETCH_INSTR_BYTES,
  parameter int unsigned FIFO_DEPTH     = FETCH_FIFO_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      imem_ack_i,
  output logic                      instr_valid_o,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                      instr_ready_i,
  output logic                      misalign_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [MEM_ADDR_WIDTH-1:0] ALIGN_MASK = MEM_ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] PC_STEP    = MEM_ADDR_WIDTH'(INSTR_BYTES);

  fetch_state_e                       state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0]          pc_q, pc_d;
  logic                               misalign_q, misalign_d;
  logic                               misaligned, redirect_ok;
  logic [MEM_ADDR_WIDTH-1:0]          redirect_tgt;
  logic                               push, pop, flush;
  logic [CNT_W-1:0]                   count, occ_next;
  logic                               fifo_empty;
  logic [MEM_ADDR_WIDTH+MEM_DATA_WIDTH-1:0] head;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign misaligned   = redirect_i && ((redirect_addr_i & ALIGN_MASK) != '0);
  assign redirect_ok  = redirect_i && !misaligned;
  assign redirect_tgt = redirect_addr_i;
`else
  assign misaligned   = 1'b0;
  assign redirect_ok  = redirect_i;
  assign redirect_tgt = redirect_addr_i & ~ALIGN_MASK;
`endif

  assign misalign_d = misaligned;
  assign flush      = redirect_ok;
  assign push       = (state_q == ST_FETCH) && imem_ack_i && !redirect_ok;
  assign pop        = instr_valid_o && instr_ready_i && !redirect_ok;

  // Occupancy after this edge; the outstanding slot is free whenever this is sampled.
  always_comb begin
    if (flush) begin
      occ_next = '0;
    end else begin
      occ_next = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: begin
        pc_d    = boot_addr_i;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (redirect_ok) begin
          pc_d = redirect_tgt;
        end
        if (occ_next < CNT_W'(FIFO_DEPTH)) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (redirect_ok) begin
          pc_d    = redirect_tgt;
          state_d = imem_ack_i ? ST_IDLE : ST_DISCARD;
        end else if (imem_ack_i) begin
          pc_d    = pc_q + PC_STEP;
          state_d = (occ_next < CNT_W'(FIFO_DEPTH)) ? ST_FETCH : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (redirect_ok) begin
          pc_d = redirect_tgt;
        end
        if (imem_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .WIDTH (MEM_ADDR_WIDTH + MEM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .flush_i (flush),
    .push_i  (push),
    .data_i  ({pc_q, imem_rdata_i}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .empty_o (fifo_empty)
  );

  assign imem_req_o    = (state_q == ST_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_pc_o    = head[MEM_ADDR_WIDTH+MEM_DATA_WIDTH-1:MEM_DATA_WIDTH];
  assign instr_o       = head[MEM_DATA_WIDTH-1:0];
  assign misalign_o    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// | tb_pc_fetch_ctrl                                                        |
// | Directed and random checks of pc_fetch_ctrl against a queue model.      |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_ctrl;
  import simple_processor_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = FETCH_FIFO_DEPTH;
  localparam int STEP  = FETCH_INSTR_BYTES;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b1;
  logic [AW-1:0] boot_addr_i = '0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_addr_i = '0;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_rdata_i = '0;
  logic          imem_ack_i = 1'b0;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i = 1'b0;
  logic          misalign_o;

  always #5 clk_i = ~clk_i;

  pc_fetch_ctrl u_dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .boot_addr_i     (boot_addr_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .imem_ack_i      (imem_ack_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i),
    .misalign_o      (misalign_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of {pc,data} plus request/discard flags.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  logic [AW-1:0] m_pc;
  logic          m_boot, m_req, m_drop, m_mis;

  // Memory responder and stimulus knobs.
  logic          mem_busy = 1'b0;
  logic [AW-1:0] mem_addr;
  int            mem_wait;
  int            lat_min = 1, lat_max = 1;
  int            force_ack = 0;
  int            ack_count = 0;
  logic [AW-1:0] acc_log[$];
  logic [AW-1:0] pop_log[$];
  logic          drv_redir = 1'b0;
  logic [AW-1:0] drv_raddr = '0;
  logic          drv_ready = 1'b0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req_o,    0);
    check({tag, "_addr"},  imem_addr_o,   0);
    check({tag, "_valid"}, instr_valid_o, 0);
    check({tag, "_instr"}, instr_o,       0);
    check({tag, "_ipc"},   instr_pc_o,    0);
    check({tag, "_mis"},   misalign_o,    0);
  endtask

  task automatic apply_reset(input logic [AW-1:0] boot, input int n);
    arst_ni       = 1'b0;
    boot_addr_i   = boot;
    redirect_i    = 1'b0;
    imem_ack_i    = 1'b0;
    instr_ready_i = 1'b0;
    m_boot = 1'b1; m_pc = '0; m_req = 1'b0; m_drop = 1'b0; m_mis = 1'b0;
    m_q.delete();
    mem_busy = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (n) begin
      @(negedge clk_i);
      check_reset_outputs("rst_hold");
    end
    arst_ni = 1'b1;
  endtask

  // Called at a falling edge: compare, drive, step the model at the rising edge.
  task automatic cycle();
    logic          ack, eff, mis, pop;
    logic [DW-1:0] rdata;
    logic [AW-1:0] tgt, seen_pc;

    check("req", imem_req_o, m_req);
    if (m_req) check("addr", imem_addr_o, m_pc);
    check("valid", instr_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("instr_pc", instr_pc_o, m_q[0].pc);
      check("instr", instr_o, m_q[0].data);
    end
    check("misalign", misalign_o, m_mis);
    seen_pc = instr_pc_o;

    ack   = 1'b0;
    rdata = DW'($urandom);
    if (mem_busy && imem_req_o) check("addr_stable", imem_addr_o, mem_addr);
    if (!mem_busy && imem_req_o) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr_o;
      mem_wait = int'($urandom_range(lat_max, lat_min));
      acc_log.push_back(imem_addr_o);
    end
    if (mem_busy) begin
      if (mem_wait == 0) begin
        ack = 1'b1;
        rdata = mem_word(mem_addr);
        mem_busy = 1'b0;
        ack_count++;
      end else begin
        mem_wait--;
      end
    end
    if (force_ack > 0) begin
      ack = 1'b1;
      force_ack--;
    end

    redirect_i      = drv_redir;
    redirect_addr_i = drv_raddr;
    instr_ready_i   = drv_ready;
    imem_ack_i      = ack;
    imem_rdata_i    = rdata;

    @(posedge clk_i);
`ifdef PC_FETCH_ALIGN_CHECK_EN
    mis = drv_redir && ((drv_raddr % STEP) != 0);
    eff = drv_redir && !mis;
    tgt = drv_raddr;
`else
    mis = 1'b0;
    eff = drv_redir;
    tgt = drv_raddr - AW'(drv_raddr % STEP);
`endif
    m_mis = mis;
    if (m_boot) begin
      m_pc   = boot_addr_i;
      m_boot = 1'b0;
    end else begin
      pop = (m_q.size() != 0) && drv_ready && !eff;
      if (pop) pop_log.push_back(seen_pc);
      if (eff) m_q.delete();
      else if (pop) m_q.delete(0);
      if (m_req) begin
        if (ack && eff) begin
          m_pc = tgt; m_req = 1'b0;
        end else if (ack) begin
          m_q.push_back('{pc: m_pc, data: rdata});
          m_pc  = m_pc + AW'(STEP);
          m_req = (m_q.size() < DEPTH);
        end else if (eff) begin
          m_pc = tgt; m_req = 1'b0; m_drop = 1'b1;
        end
      end else if (m_drop) begin
        if (eff) m_pc = tgt;
        if (ack) m_drop = 1'b0;
      end else begin
        if (eff) m_pc = tgt;
        m_req = (m_q.size() < DEPTH);
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    int acc_n;
    logic found;

    @(negedge clk_i);
    apply_reset(16'h0100, 2);

    // Sequential fetch with a one-cycle memory and an always-ready consumer.
    drv_ready = 1'b1; lat_min = 1; lat_max = 1;
    pop_log.delete();
    repeat (14) cycle();
    check("seq_pc0", pop_log[0], 16'h0100);
    check("seq_pc1", pop_log[1], 16'h0102);
    check("seq_pc2", pop_log[2], 16'h0104);

    // Stalled consumer fills the buffer, then a single pop frees one slot.
    apply_reset(16'h0100, 1);
    drv_ready = 1'b0; ack_count = 0;
    repeat (20) cycle();
    check("fill_acks", ack_count, 4);
    check("fill_req_low", imem_req_o, 0);
    acc_n = acc_log.size();
    drv_ready = 1'b1;
    cycle();
    drv_ready = 1'b0;
    repeat (10) cycle();
    check("one_more_req", acc_log.size() - acc_n, 1);
    check("refill_req_low", imem_req_o, 0);

    // Redirect while the 0x0106 fetch is outstanding; its response arrives late.
    apply_reset(16'h0100, 1);
    drv_ready = 1'b0; acc_log.delete();
    for (int i = 0; i < 40 && !(m_req && m_pc == 16'h0106); i++) cycle();
    check("reach_0106_req", imem_req_o, 1);
    check("reach_0106_addr", imem_addr_o, 16'h0106);
    lat_min = 3; lat_max = 3;
    drv_redir = 1'b1; drv_raddr = 16'h0200;
    cycle();
    drv_redir = 1'b0; lat_min = 1; lat_max = 1;
    check("flush_valid", instr_valid_o, 0);
    repeat (8) cycle();
    check("redir_next_req", acc_log[4], 16'h0200);
    check("redir_head_pc", instr_pc_o, 16'h0200);

    // Misaligned redirect target.
    apply_reset(16'h0100, 1);
    drv_ready = 1'b1;
    repeat (6) cycle();
    acc_n = acc_log.size();
    drv_redir = 1'b1; drv_raddr = 16'h0201;
    cycle();
    drv_redir = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    check("misalign_flag", misalign_o, 1);
`else
    check("misalign_flag", misalign_o, 0);
`endif
    repeat (6) cycle();
    found = 1'b0;
    for (int i = acc_n; i < acc_log.size(); i++)
      if (acc_log[i] == 16'h0200) found = 1'b1;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    check("misalign_fetch", found, 0);
`else
    check("misalign_fetch", found, 1);
`endif

    // PC wraps at the top of the address space.
    apply_reset(16'hFFFE, 1);
    acc_log.delete();
    repeat (8) cycle();
    check("wrap_first", acc_log[0], 16'hFFFE);
    check("wrap_next", acc_log[1], 16'h0000);

    // Reset with a request in flight, plus stray acks right after release.
    apply_reset(16'h0100, 1);
    lat_min = 3; lat_max = 3;
    repeat (3) cycle();
    check("pre_rst_req", imem_req_o, 1);
    apply_reset(16'h0300, 2);
    force_ack = 2; lat_min = 1; lat_max = 1;
    acc_log.delete();
    repeat (8) cycle();
    check("post_rst_first", acc_log[0], 16'h0300);

    // Random traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399, 0) == 0)
        apply_reset(AW'($urandom) & ~AW'(STEP - 1), int'($urandom_range(2, 1)));
      drv_ready = ($urandom_range(3, 0) != 0);
      drv_redir = !m_boot && ($urandom_range(15, 0) == 0);
      drv_raddr = AW'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
